// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - commits host download bytes to SDRAM ROM pages and the ROM-present map
// Optional feature: define ROM_LOADER_COMBO_EN for "Z0" combo expansion ROM support.
module rom_loader #(
  parameter logic [8:0] MF2_PAGE = 9'h1FF,
  parameter logic [8:0] BAD_PAGE = 9'h1EE
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_ref,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  input  logic [31:0] ioctl_file_ext,
  output logic        ioctl_wait,
  output logic        boot_wr,
  output logic [22:0] boot_a,
  output logic [1:0]  boot_bank,
  output logic [7:0]  boot_dout,
  output logic        map_wr,
  output logic [7:0]  map_idx
);

  typedef enum logic [1:0] {IDLE, ARM, WRITE} state_t;

  localparam logic [15:0] EXT_ZZ = 16'h5A5A;
  localparam logic [15:0] EXT_Z0 = 16'h5A30;

  state_t      state, state_nx;
  logic        dl_d;
  logic [8:0]  page;
  logic [8:0]  page_ld;
  logic        dual;
  logic        dl_rise;
  logic        accept;
  logic        base_drop;
  logic        second;
  logic        done;
  logic        combo_done;
  logic [4:0]  hi_nib;
  logic [4:0]  lo_nib;
  logic [8:0]  wr_page;
  logic        unused_ext;

  assign unused_ext = &{1'b0, ioctl_file_ext[31:16]};

  // Returns {valid, value} for an uppercase hex digit character.
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46) return {1'b1, c[3:0] + 4'd9};
    else return 5'd0;
  endfunction

  assign dl_rise    = ioctl_download & ~dl_d & (ioctl_index != 8'd0);
  assign base_drop  = (ioctl_index == 8'd0) & (|ioctl_addr[24:17]);
  assign accept     = (state == IDLE) & ioctl_wr & ioctl_download & dl_d & ~base_drop;

`ifdef ROM_LOADER_COMBO_EN
  logic combo;
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) combo <= 1'b0;
    else if (dl_rise) combo <= (ioctl_file_ext[15:0] == EXT_Z0);
    else if (combo_done) combo <= 1'b0;
  end
`else
  logic combo;
  assign combo = 1'b0;
`endif

  assign combo_done = done & combo & (boot_a[13:0] == 14'h3FFF);

  always_comb begin
    hi_nib  = hex_nib(ioctl_file_ext[15:8]);
    lo_nib  = hex_nib(ioctl_file_ext[7:0]);
    page_ld = BAD_PAGE;
    if (hi_nib[4]) page_ld[7:4] = hi_nib[3:0];
    if (lo_nib[4]) page_ld[3:0] = lo_nib[3:0];
    if (ioctl_file_ext[15:0] == EXT_ZZ || ioctl_file_ext[15:0] == EXT_Z0) page_ld = 9'd0;
  end

  // Base image: 16 KB slots, slots 4-7 mirror 0-3 into bank 1.
  always_comb begin
    wr_page = {page[8], page[7:0] + ioctl_addr[21:14]};
    if (ioctl_index == 8'd0) begin
      case (ioctl_addr[15:14])
        2'd0:    wr_page = 9'h000;
        2'd1:    wr_page = 9'h100;
        2'd2:    wr_page = 9'h107;
        default: wr_page = MF2_PAGE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    ioctl_wait = (state != IDLE);
    boot_wr    = (state == WRITE);
    second     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (accept) state_nx = ARM;
      ARM:   if (ce_ref) state_nx = WRITE;
      WRITE: begin
        if (ce_ref) begin
          if (dual && boot_bank == 2'd0) begin
            state_nx = ARM;
            second   = 1'b1;
          end else begin
            state_nx = IDLE;
            done     = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_d      <= 1'b0;
      page      <= 9'd0;
      dual      <= 1'b0;
      boot_a    <= 23'd0;
      boot_bank <= 2'd0;
      boot_dout <= 8'd0;
      map_wr    <= 1'b0;
      map_idx   <= 8'd0;
    end else begin
      dl_d   <= ioctl_download;
      map_wr <= 1'b0;
      if (accept) begin
        boot_a    <= {wr_page, ioctl_addr[13:0]};
        boot_dout <= ioctl_dout;
        dual      <= (ioctl_index[7:6] == 2'b01) | (|ioctl_index[5:0]);
        if (ioctl_index == 8'd0) boot_bank <= {1'b0, ioctl_addr[16]};
        else                     boot_bank <= {1'b0, &ioctl_index[7:6]};
      end
      if (second) boot_bank <= 2'd1;
      if (done && boot_a[22]) begin
        map_wr  <= 1'b1;
        map_idx <= boot_a[21:14];
      end
      if (combo_done) page <= MF2_PAGE;
      if (dl_rise)    page <= page_ld;
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - table-driven scoreboard bench for rom_loader
module tb_rom_loader;

  logic        clk_sys;
  logic        reset;
  logic        ce_ref;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic [31:0] ioctl_file_ext;
  logic        ioctl_wait;
  logic        boot_wr;
  logic [22:0] boot_a;
  logic [1:0]  boot_bank;
  logic [7:0]  boot_dout;
  logic        map_wr;
  logic [7:0]  map_idx;

  rom_loader dut (
    .clk_sys(clk_sys), .reset(reset), .ce_ref(ce_ref),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index), .ioctl_file_ext(ioctl_file_ext),
    .ioctl_wait(ioctl_wait), .boot_wr(boot_wr), .boot_a(boot_a), .boot_bank(boot_bank),
    .boot_dout(boot_dout), .map_wr(map_wr), .map_idx(map_idx)
  );

  typedef struct {
    logic [22:0] a;
    logic [1:0]  bank;
    logic [7:0]  d;
  } wr_t;

  typedef struct {
    logic [7:0]  idx;
    logic [15:0] ext;
    logic [24:0] addr;
    logic [7:0]  d;
    bit          acc;
    logic [22:0] a_exp;
    logic [1:0]  bank;
    int          nwr;
  } vec_t;

  localparam int NV = 15;
  vec_t vt [NV];
  wr_t  wq [$];
  logic [7:0] mq [$];
  wr_t  e;
  logic bw_prev;
  int   total;
  int   bad;
  logic [3:0] ce_cnt;

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  initial begin
    ce_ref = 1'b0;
    ce_cnt = 4'd0;
    forever begin
      @(posedge clk_sys); #1;
      ce_cnt = ce_cnt + 4'd1;
      ce_ref = (ce_cnt == 4'd0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys); #1;
  endtask

  // Scoreboard side: every boot_wr rise and map_wr pulse must match the queue head.
  always @(negedge clk_sys) begin
    if (!reset) begin
      if (boot_wr && !bw_prev) begin
        if (wq.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_boot_wr actual_a=%h required=none", boot_a);
        end else begin
          e = wq.pop_front();
          check("boot_a", {9'd0, boot_a}, {9'd0, e.a});
          check("boot_bank", {30'd0, boot_bank}, {30'd0, e.bank});
          check("boot_dout", {24'd0, boot_dout}, {24'd0, e.d});
          check("wait_during_write", {31'd0, ioctl_wait}, 32'd1);
        end
      end
      if (map_wr) begin
        if (mq.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_map_wr actual_idx=%h required=none", map_idx);
        end else begin
          check("map_idx", {24'd0, map_idx}, {24'd0, mq.pop_front()});
        end
      end
    end
    bw_prev = boot_wr;
  end

  task automatic start_dl(input logic [7:0] idx, input logic [15:0] ext);
    ioctl_download = 1'b0;
    tick(); tick();
    ioctl_index    = idx;
    ioctl_file_ext = {16'h0000, ext};
    ioctl_download = 1'b1;
    tick(); tick();
  endtask

  task automatic expect_wr(input logic [22:0] a, input logic [1:0] bank, input logic [7:0] d, input int nwr);
    wq.push_back('{a, bank, d});
    if (nwr == 2) wq.push_back('{a, 2'd1, d});
    if (a[22]) mq.push_back(a[21:14]);
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit acc,
                           input int nwr, input bit drop);
    int n;
    int seen;
    bit wait_ok;
    bit prev_wr;
    bit any;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    if (drop) ioctl_download = 1'b0;
    if (acc) begin
      check("wait_after_accept", {31'd0, ioctl_wait}, 32'd1);
      n = 0;
      wait_ok = 1'b1;
      while (!boot_wr && n < 40) begin
        wait_ok &= ioctl_wait;
        tick();
        n++;
      end
      check("first_write_latency_le17", {31'd0, (n <= 17)}, 32'd1);
      seen = 0;
      prev_wr = 1'b0;
      n = 0;
      while (ioctl_wait && n < 200) begin
        if (boot_wr && !prev_wr) seen++;
        prev_wr = boot_wr;
        tick();
        n++;
      end
      check("wait_released", {31'd0, ioctl_wait}, 32'd0);
      check("writes_under_wait", seen, nwr);
      check("wait_held_to_write", {31'd0, wait_ok}, 32'd1);
    end else begin
      any = 1'b0;
      for (int i = 0; i < 40; i++) begin
        any |= ioctl_wait | boot_wr;
        tick();
      end
      check("discard_quiet", {31'd0, any}, 32'd0);
    end
    tick(); tick();
  endtask

  initial begin
    int n;
    total = 0;
    bad   = 0;
    bw_prev = 1'b0;
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    ioctl_index    = '0;
    ioctl_file_ext = '0;

    //           idx    ext       addr         d      acc  a_exp        bank nwr
    vt[0]  = '{8'h00, 16'h0000, 25'h0004123, 8'h5A, 1'b1, 23'h400123, 2'd0, 1};
    vt[1]  = '{8'h00, 16'h0000, 25'h0000ABC, 8'h11, 1'b1, 23'h000ABC, 2'd0, 1};
    vt[2]  = '{8'h00, 16'h0000, 25'h0008005, 8'h22, 1'b1, 23'h41C005, 2'd0, 1};
    vt[3]  = '{8'h00, 16'h0000, 25'h000C3FF, 8'h33, 1'b1, 23'h7FC3FF, 2'd0, 1};
    vt[4]  = '{8'h00, 16'h0000, 25'h0010000, 8'h44, 1'b1, 23'h000000, 2'd1, 1};
    vt[5]  = '{8'h00, 16'h0000, 25'h001C001, 8'h55, 1'b1, 23'h7FC001, 2'd1, 1};
    vt[6]  = '{8'h01, 16'h3037, 25'h0000010, 8'h66, 1'b1, 23'h41C010, 2'd0, 2};
    vt[7]  = '{8'h01, 16'h5137, 25'h0000000, 8'h77, 1'b1, 23'h79C000, 2'd0, 2};
    vt[8]  = '{8'h01, 16'h5151, 25'h0000000, 8'h88, 1'b1, 23'h7B8000, 2'd0, 2};
    vt[9]  = '{8'hC0, 16'h4135, 25'h0004020, 8'h99, 1'b1, 23'h698020, 2'd1, 1};
    vt[10] = '{8'h40, 16'h4646, 25'h003C000, 8'hAA, 1'b1, 23'h438000, 2'd0, 2};
    vt[11] = '{8'h01, 16'h5A5A, 25'h0004005, 8'hBB, 1'b1, 23'h004005, 2'd0, 2};
    vt[12] = '{8'h80, 16'h3962, 25'h0000000, 8'hCC, 1'b1, 23'h678000, 2'd0, 1};
    vt[13] = '{8'h00, 16'h0000, 25'h0020000, 8'hDD, 1'b0, 23'h000000, 2'd0, 0};
    vt[14] = '{8'h00, 16'h0000, 25'h1FFFFFF, 8'hEE, 1'b0, 23'h000000, 2'd0, 0};

    repeat (3) tick();
    check("rst_wait", {31'd0, ioctl_wait}, 32'd0);
    check("rst_boot_wr", {31'd0, boot_wr}, 32'd0);
    check("rst_map_wr", {31'd0, map_wr}, 32'd0);
    check("rst_boot_a", {9'd0, boot_a}, 32'd0);
    check("rst_boot_bank", {30'd0, boot_bank}, 32'd0);
    check("rst_boot_dout", {24'd0, boot_dout}, 32'd0);
    check("rst_map_idx", {24'd0, map_idx}, 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) begin
      start_dl(vt[i].idx, vt[i].ext);
      if (vt[i].acc) expect_wr(vt[i].a_exp, vt[i].bank, vt[i].d, vt[i].nwr);
      send_byte(vt[i].addr, vt[i].d, vt[i].acc, vt[i].nwr, 1'b0);
    end

    // Z0 combo stream: pages switch after the byte at 0x3FFF completes.
    start_dl(8'hC0, 16'h5A30);
    expect_wr(23'h000000, 2'd1, 8'h01, 1);
    send_byte(25'h0000000, 8'h01, 1'b1, 1, 1'b0);
    expect_wr(23'h003FFF, 2'd1, 8'h02, 1);
    send_byte(25'h0003FFF, 8'h02, 1'b1, 1, 1'b0);
`ifdef ROM_LOADER_COMBO_EN
    expect_wr(23'h400000, 2'd1, 8'h03, 1);
    send_byte(25'h0004000, 8'h03, 1'b1, 1, 1'b0);
    expect_wr(23'h407FFF, 2'd1, 8'h04, 1);
    send_byte(25'h0007FFF, 8'h04, 1'b1, 1, 1'b0);
`else
    expect_wr(23'h004000, 2'd1, 8'h03, 1);
    send_byte(25'h0004000, 8'h03, 1'b1, 1, 1'b0);
    expect_wr(23'h007FFF, 2'd1, 8'h04, 1);
    send_byte(25'h0007FFF, 8'h04, 1'b1, 1, 1'b0);
`endif

    // Download dropping right after acceptance still completes the byte.
    start_dl(8'h00, 16'h0000);
    expect_wr(23'h400001, 2'd0, 8'h77, 1);
    send_byte(25'h0004001, 8'h77, 1'b1, 1, 1'b1);

    // ioctl_wr while busy is ignored.
    start_dl(8'h00, 16'h0000);
    expect_wr(23'h000100, 2'd0, 8'h33, 1);
    ioctl_addr = 25'h0000100; ioctl_dout = 8'h33; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    tick(); tick();
    ioctl_addr = 25'h0004000; ioctl_dout = 8'h44; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    n = 0;
    while (ioctl_wait && n < 200) begin tick(); n++; end
    check("busy_wr_done", {31'd0, ioctl_wait}, 32'd0);
    repeat (40) tick();

    // A write strobe on the cycle download rises is ignored.
    ioctl_download = 1'b0;
    tick(); tick();
    ioctl_index = 8'h00; ioctl_addr = 25'h0004000; ioctl_dout = 8'h5F;
    ioctl_download = 1'b1; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (ioctl_wait) n++;
      tick();
    end
    check("wr_on_rise_ignored", n, 0);

    // Reset in the middle of WRITE aborts with no map update.
    start_dl(8'h00, 16'h0000);
    wq.push_back('{23'h400002, 2'd0, 8'h99});
    ioctl_addr = 25'h0004002; ioctl_dout = 8'h99; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    n = 0;
    while (!boot_wr && n < 40) begin tick(); n++; end
    check("reached_write", {31'd0, boot_wr}, 32'd1);
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    check("midrst_boot_wr", {31'd0, boot_wr}, 32'd0);
    check("midrst_wait", {31'd0, ioctl_wait}, 32'd0);
    check("midrst_map_wr", {31'd0, map_wr}, 32'd0);
    check("midrst_boot_a", {9'd0, boot_a}, 32'd0);
    check("midrst_map_idx", {24'd0, map_idx}, 32'd0);
    tick(); tick();
    reset = 1'b0;
    repeat (40) tick();

    check("write_queue_drained", wq.size(), 0);
    check("map_queue_drained", mq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
